// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage hazard, redirect, imem and decode-side signal bundle
interface fetch_stage_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        BranchTakenE;
    logic [31:0] BranchTargetE;
    logic        PCSrcW;
    logic [31:0] ResultW;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        ValidD;

    modport master (
        input  StallF, StallD, FlushD,
        input  BranchTakenE, BranchTargetE,
        input  PCSrcW, ResultW,
        input  InstrF,
        output PCF, InstrD, PCPlus8D, ValidD
    );

    modport slave (
        output StallF, StallD, FlushD,
        output BranchTakenE, BranchTargetE,
        output PCSrcW, ResultW,
        output InstrF,
        input  PCF, InstrD, PCPlus8D, ValidD
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, next-PC select and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr_q;
    logic [31:0] pc_plus8_q;
    logic        valid_q;

    // Sequential successor and redirect target; execute branch outranks writeback PC write.
    // Decode sees PCD+8, i.e. the PC two words past the fetched instruction.
    always_comb begin
        pc_plus4        = pc_q + 32'd4;
        pc_plus8        = pc_q + 32'd8;
        redirect        = bus.BranchTakenE | bus.PCSrcW;
        redirect_target = (bus.BranchTakenE ? bus.BranchTargetE : bus.ResultW) & 32'hFFFF_FFFC;
    end

    // PC register: a redirect is never dropped, even under a fetch stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= redirect_target;
        end else if (!bus.StallF) begin
            pc_q <= pc_plus4;
        end
    end

    // IF/ID register: flush beats stall and inserts a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus8_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (bus.FlushD) begin
            instr_q    <= NOP_INSTR;
            pc_plus8_q <= pc_plus8;
            valid_q    <= 1'b0;
        end else if (!bus.StallD) begin
            instr_q    <= bus.InstrF;
            pc_plus8_q <= pc_plus8;
            valid_q    <= 1'b1;
        end
    end

    assign bus.PCF      = pc_q;
    assign bus.InstrD   = instr_q;
    assign bus.PCPlus8D = pc_plus8_q;
    assign bus.ValidD   = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'hE1A00000;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'hE3A00000 + (a >> 2);
    endfunction

    assign bus.InstrF = imem(bus.PCF);

    // Reference: where the program is and what decode holds, as plain values.
    logic [31:0] m_pc, m_instr, m_pc8;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pc8 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, bus.PCF, m_pc);
        check({tag, ".instr"}, bus.InstrD, m_instr);
        check({tag, ".valid"}, {31'h0, bus.ValidD}, {31'h0, m_valid});
        if (m_valid) check({tag, ".pc8"}, bus.PCPlus8D, m_pc8);
    endtask

    // One clock: advance the reference from the current inputs, then compare.
    task automatic cycle(input string tag);
        logic [31:0] npc;
        if (bus.BranchTakenE)      npc = {bus.BranchTargetE[31:2], 2'b00};
        else if (bus.PCSrcW)       npc = {bus.ResultW[31:2], 2'b00};
        else if (bus.StallF)       npc = m_pc;
        else                       npc = m_pc + 4;
        if (bus.FlushD) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (!bus.StallD) begin
            m_instr = imem(m_pc); m_pc8 = m_pc + 8; m_valid = 1'b1;
        end
        m_pc = npc;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic bt,
                         input logic [31:0] tgt, input logic pw, input logic [31:0] res);
        bus.StallF = sf; bus.StallD = sd; bus.FlushD = fd;
        bus.BranchTakenE = bt; bus.BranchTargetE = tgt;
        bus.PCSrcW = pw; bus.ResultW = res;
    endtask

    initial begin
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        reset = 1'b1;
        #2;
        model_reset();
        check("reset.pc", bus.PCF, 32'h0);
        check("reset.instr", bus.InstrD, NOP);
        check("reset.pc8", bus.PCPlus8D, 32'h0);
        check("reset.valid", {31'h0, bus.ValidD}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Free run from reset.
        cycle("run0");
        check("run0.pc_const", bus.PCF, 32'h4);
        check("run0.instr_const", bus.InstrD, 32'hE3A00000);
        check("run0.pc8_const", bus.PCPlus8D, 32'h8);
        cycle("run1");
        check("run1.pc8_const", bus.PCPlus8D, 32'hC);
        cycle("run2");
        cycle("run3");
        check("run3.pc_const", bus.PCF, 32'h10);

        // Two-cycle stall at PCF = 0x10.
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        cycle("stall0");
        cycle("stall1");
        check("stall1.pc_const", bus.PCF, 32'h10);
        check("stall1.instr_const", bus.InstrD, 32'hE3A00003);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle("resume");
        check("resume.pc_const", bus.PCF, 32'h14);
        cycle("run4");

        // Taken branch with flush at PCF = 0x18.
        check("pre_branch.pc_const", bus.PCF, 32'h18);
        drive(0, 0, 1, 1, 32'h40, 0, 32'h0);
        cycle("branch");
        check("branch.pc_const", bus.PCF, 32'h40);
        check("branch.instr_const", bus.InstrD, NOP);
        check("branch.valid_const", {31'h0, bus.ValidD}, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle("after_branch");
        check("after_branch.instr_const", bus.InstrD, 32'hE3A00010);

        // Branch outranks writeback redirect.
        drive(0, 0, 1, 1, 32'h80, 1, 32'h100);
        cycle("both");
        check("both.pc_const", bus.PCF, 32'h80);
        // Writeback redirect under stall, misaligned target.
        drive(1, 0, 1, 0, 32'h0, 1, 32'h103);
        cycle("pcw_stall");
        check("pcw_stall.pc_const", bus.PCF, 32'h100);

        // Wrap at the top of the address space.
        drive(0, 0, 1, 0, 32'h0, 1, 32'hFFFFFFFC);
        cycle("to_top");
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle("wrap");
        check("wrap.pc_const", bus.PCF, 32'h0);
        check("wrap.instr_const", bus.InstrD, 32'hE3A00000 + 32'h3FFFFFFF);

        // Flush outranks stall.
        drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
        cycle("flush_stall");
        check("flush_stall.instr_const", bus.InstrD, NOP);
        check("flush_stall.valid_const", {31'h0, bus.ValidD}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), $urandom(),
                  ($urandom_range(0, 9) == 0), $urandom());
            cycle("rand");
        end

        // Asynchronous reset between edges.
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle("pre_areset");
        #3 reset = 1'b1;
        #1;
        model_reset();
        check("areset.pc", bus.PCF, 32'h0);
        check("areset.valid", {31'h0, bus.ValidD}, 32'h0);
        check("areset.instr", bus.InstrD, NOP);
        @(posedge clk);
        #1 reset = 1'b0;
        cycle("post_areset");
        check("post_areset.pc_const", bus.PCF, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
